// File: rtl/uart_pkg.sv
// Shared constants for the UART host register front end: address map, field
// positions, FSM encoding and reset line configuration.
package uart_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_CONFIG  = 3'd2;
  localparam logic [2:0] ADDR_DIV_LO  = 3'd3;
  localparam logic [2:0] ADDR_DIV_MID = 3'd4;
  localparam logic [2:0] ADDR_DIV_HI  = 3'd5;
  localparam logic [2:0] ADDR_IRQ_EN  = 3'd6;

  localparam int ST_RX_AVAIL     = 0;
  localparam int ST_TX_SPACE     = 1;
  localparam int ST_PARITY_ERR   = 2;
  localparam int ST_OVERFLOW     = 3;
  localparam int ST_TX_DROPPED   = 4;
  localparam int ST_RX_UNDERFLOW = 5;

  localparam int CFG_DATA_BITS   = 0;
  localparam int CFG_HAS_PARITY  = 2;
  localparam int CFG_PARITY_MODE = 3;
  localparam int CFG_EXTRA_STOP  = 5;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_TX_WAIT = 2'd1;
  localparam logic [1:0] S_RX_WAIT = 2'd2;
  localparam logic [1:0] S_ACK     = 2'd3;

  typedef struct packed {
    logic       extra_stop;
    logic [1:0] parity_mode;
    logic       has_parity;
    logic [1:0] data_bits;
  } uart_cfg_t;

  localparam uart_cfg_t CFG_RST = '{extra_stop: 1'b0, parity_mode: 2'd0,
                                    has_parity: 1'b0, data_bits: 2'd3};

  function automatic uart_cfg_t byte_to_cfg(input logic [7:0] b);
    uart_cfg_t c;
    c.data_bits   = b[CFG_DATA_BITS +: 2];
    c.has_parity  = b[CFG_HAS_PARITY];
    c.parity_mode = b[CFG_PARITY_MODE +: 2];
    c.extra_stop  = b[CFG_EXTRA_STOP];
    return c;
  endfunction

endpackage

// File: rtl/uart_host_fsm.sv
// DATA-register transaction sequencer: turns a host DATA access into a
// req/ack handshake on the UART TX or RX FIFO, then requests a bus ack.
module uart_host_fsm
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe_i,
  input  logic       is_data_i,
  input  logic       write_i,
  input  logic [7:0] wr_data_i,
  input  logic       uart_full_i,
  input  logic       uart_empty_i,
  input  logic       write_ack_i,
  input  logic       read_ack_i,
  input  logic [7:0] read_byte_i,
  output logic       idle_o,
  output logic       ack_o,
  output logic       ack_rd_o,
  output logic [7:0] rd_byte_o,
  output logic       rx_capture_o,
  output logic       set_tx_dropped_o,
  output logic       set_rx_underflow_o,
  output logic       write_req_o,
  output logic       read_req_o,
  output logic [7:0] data_in_o
);

  logic [1:0] state_q, state_d;
  logic       wr_req_q, wr_req_d;
  logic       rd_req_q, rd_req_d;
  logic       is_rd_q, is_rd_d;
  logic [7:0] din_q, din_d;
  logic [7:0] rx_byte_q, rx_byte_d;

  always_comb begin
    state_d            = state_q;
    wr_req_d           = wr_req_q;
    rd_req_d           = rd_req_q;
    is_rd_d            = is_rd_q;
    din_d              = din_q;
    rx_byte_d          = rx_byte_q;
    set_tx_dropped_o   = 1'b0;
    set_rx_underflow_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (strobe_i && is_data_i) begin
          is_rd_d = !write_i;
          if (write_i) begin
            if (uart_full_i) begin
              set_tx_dropped_o = 1'b1;
              state_d          = S_ACK;
            end else begin
              din_d    = wr_data_i;
              wr_req_d = 1'b1;
              state_d  = S_TX_WAIT;
            end
          end else if (uart_empty_i) begin
            set_rx_underflow_o = 1'b1;
            rx_byte_d          = 8'h00;
            state_d            = S_ACK;
          end else begin
            rd_req_d = 1'b1;
            state_d  = S_RX_WAIT;
          end
        end
      end
      S_TX_WAIT: begin
        if (write_ack_i) begin
          wr_req_d = 1'b0;
          state_d  = S_ACK;
        end
      end
      S_RX_WAIT: begin
        if (read_ack_i) begin
          rx_byte_d = read_byte_i;
          rd_req_d  = 1'b0;
          state_d   = S_ACK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      is_rd_q   <= 1'b0;
      din_q     <= 8'h00;
      rx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_req_q  <= wr_req_d;
      rd_req_q  <= rd_req_d;
      is_rd_q   <= is_rd_d;
      din_q     <= din_d;
      rx_byte_q <= rx_byte_d;
    end
  end

  assign idle_o       = (state_q == S_IDLE);
  assign ack_o        = (state_q == S_ACK);
  assign ack_rd_o     = is_rd_q;
  assign rd_byte_o    = rx_byte_q;
  assign rx_capture_o = (state_q == S_RX_WAIT) && read_ack_i;
  assign write_req_o  = wr_req_q;
  assign read_req_o   = rd_req_q;
  assign data_in_o    = din_q;

endmodule

// File: rtl/uart_host_regs.sv
// Byte-wide host register file for one BufferedUart: line config, divisor,
// status/sticky flags, interrupt enable, and the DATA FIFO sequencer.
module uart_host_regs
  import uart_pkg::*;
#(
  parameter int CLOCK_DIVISOR_WIDTH = 24,
  parameter int DIVISOR_RESET       = 104
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           busStrobe,
  input  logic                           busWrite,
  input  logic [2:0]                     busAddr,
  input  logic [7:0]                     busWrData,
  output logic [7:0]                     busRdData,
  output logic                           busAck,
  output logic                           irq,
  output logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
  output logic [1:0]                     dataBits,
  output logic                           hasParity,
  output logic [1:0]                     parityMode,
  output logic                           extraStopBit,
  input  logic                           uartEmpty,
  output logic                           uartReadReq,
  input  logic                           uartReadAck,
  input  logic [10:0]                    uartDataOut,
  input  logic                           uartFull,
  output logic                           uartWriteReq,
  input  logic                           uartWriteAck,
  output logic [10:0]                    uartDataIn
);

  // Divisor bits above the configured width are never stored, so they read 0.
  localparam logic [23:0] DIV_MASK = 24'((33'd1 << CLOCK_DIVISOR_WIDTH) - 33'd1);
  localparam logic [23:0] DIV_RST  = 24'(DIVISOR_RESET) & DIV_MASK;

  logic       fsm_idle, fsm_ack, fsm_ack_rd, rx_capture, set_txd, set_rxu;
  logic [7:0] fsm_rd_byte, fsm_din;

  uart_cfg_t  cfg_q, cfg_d;
  logic [23:0] div_q, div_d;
  logic [2:0] irq_en_q, irq_en_d;
  logic       txd_q, txd_d, rxu_q, rxu_d, par_q, par_d, ovf_q, ovf_d;
  logic       ack_q, irq_q;
  logic [7:0] rd_q, rd_d, rd_mux, status;
  logic       reg_access, reg_wr;

  uart_host_fsm u_fsm (
    .clk                (clk),
    .rst                (rst),
    .strobe_i           (busStrobe),
    .is_data_i          (busAddr == ADDR_DATA),
    .write_i            (busWrite),
    .wr_data_i          (busWrData),
    .uart_full_i        (uartFull),
    .uart_empty_i       (uartEmpty),
    .write_ack_i        (uartWriteAck),
    .read_ack_i         (uartReadAck),
    .read_byte_i        (uartDataOut[7:0]),
    .idle_o             (fsm_idle),
    .ack_o              (fsm_ack),
    .ack_rd_o           (fsm_ack_rd),
    .rd_byte_o          (fsm_rd_byte),
    .rx_capture_o       (rx_capture),
    .set_tx_dropped_o   (set_txd),
    .set_rx_underflow_o (set_rxu),
    .write_req_o        (uartWriteReq),
    .read_req_o         (uartReadReq),
    .data_in_o          (fsm_din)
  );

  assign reg_access = busStrobe && fsm_idle && (busAddr != ADDR_DATA);
  assign reg_wr     = reg_access && busWrite;
  assign status     = {2'b00, rxu_q, txd_q, ovf_q, par_q, ~uartFull, ~uartEmpty};

  always_comb begin
    rd_mux = 8'h00;
    case (busAddr)
      ADDR_STATUS:  rd_mux = status;
      ADDR_CONFIG:  rd_mux = {2'b00, cfg_q};
      ADDR_DIV_LO:  rd_mux = div_q[7:0];
      ADDR_DIV_MID: rd_mux = div_q[15:8];
      ADDR_DIV_HI:  rd_mux = div_q[23:16];
      ADDR_IRQ_EN:  rd_mux = {5'b00000, irq_en_q};
      default:      rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    cfg_d    = cfg_q;
    div_d    = div_q;
    irq_en_d = irq_en_q;
    par_d    = par_q;
    ovf_d    = ovf_q;
    // Sticky set takes priority over a same-cycle clear.
    txd_d    = set_txd | (txd_q & ~(reg_wr && busAddr == ADDR_STATUS && busWrData[ST_TX_DROPPED]));
    rxu_d    = set_rxu | (rxu_q & ~(reg_wr && busAddr == ADDR_STATUS && busWrData[ST_RX_UNDERFLOW]));
    if (reg_wr) begin
      case (busAddr)
        ADDR_CONFIG:  cfg_d = byte_to_cfg(busWrData);
        ADDR_DIV_LO:  div_d[7:0]   = busWrData & DIV_MASK[7:0];
        ADDR_DIV_MID: div_d[15:8]  = busWrData & DIV_MASK[15:8];
        ADDR_DIV_HI:  div_d[23:16] = busWrData & DIV_MASK[23:16];
        ADDR_IRQ_EN:  irq_en_d = busWrData[2:0];
        default: ;
      endcase
    end
    if (rx_capture) begin
      par_d = uartDataOut[8];
      ovf_d = uartDataOut[9];
    end
    rd_d = rd_q;
    if (fsm_ack && fsm_ack_rd) rd_d = fsm_rd_byte;
    else if (reg_access && !busWrite) rd_d = rd_mux;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q    <= CFG_RST;
      div_q    <= DIV_RST;
      irq_en_q <= 3'b000;
      txd_q    <= 1'b0;
      rxu_q    <= 1'b0;
      par_q    <= 1'b0;
      ovf_q    <= 1'b0;
      rd_q     <= 8'h00;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      div_q    <= div_d;
      irq_en_q <= irq_en_d;
      txd_q    <= txd_d;
      rxu_q    <= rxu_d;
      par_q    <= par_d;
      ovf_q    <= ovf_d;
      rd_q     <= rd_d;
      ack_q    <= fsm_ack | reg_access;
      irq_q    <= |(irq_en_q & {txd_q | rxu_q, ~uartFull, ~uartEmpty});
    end
  end

  assign busAck       = ack_q;
  assign busRdData    = rd_q;
  assign irq          = irq_q;
  assign clockDivisor = div_q[CLOCK_DIVISOR_WIDTH-1:0];
  assign dataBits     = cfg_q.data_bits;
  assign hasParity    = cfg_q.has_parity;
  assign parityMode   = cfg_q.parity_mode;
  assign extraStopBit = cfg_q.extra_stop;
  assign uartDataIn   = {3'b000, fsm_din};

endmodule

// File: tb/tb_uart_host_regs.sv
// Directed bench for uart_host_regs: bus accesses push expected responses to a
// scoreboard that a separate monitor checks on every busAck.
module tb_uart_host_regs;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busStrobe = 1'b0, busWrite = 1'b0;
  logic [2:0]  busAddr = 3'd0;
  logic [7:0]  busWrData = 8'h00;
  logic [7:0]  busRdData;
  logic        busAck, irq;
  logic [23:0] clockDivisor;
  logic [1:0]  dataBits, parityMode;
  logic        hasParity, extraStopBit;
  logic        uartEmpty = 1'b1, uartFull = 1'b0;
  logic        uartReadReq, uartWriteReq;
  logic        uartReadAck = 1'b0, uartWriteAck = 1'b0;
  logic [10:0] uartDataOut = 11'h000;
  logic [10:0] uartDataIn;

  uart_host_regs #(.CLOCK_DIVISOR_WIDTH(24), .DIVISOR_RESET(104)) dut (
    .clk(clk), .rst(rst), .busStrobe(busStrobe), .busWrite(busWrite),
    .busAddr(busAddr), .busWrData(busWrData), .busRdData(busRdData),
    .busAck(busAck), .irq(irq), .clockDivisor(clockDivisor),
    .dataBits(dataBits), .hasParity(hasParity), .parityMode(parityMode),
    .extraStopBit(extraStopBit), .uartEmpty(uartEmpty),
    .uartReadReq(uartReadReq), .uartReadAck(uartReadAck),
    .uartDataOut(uartDataOut), .uartFull(uartFull),
    .uartWriteReq(uartWriteReq), .uartWriteAck(uartWriteAck),
    .uartDataIn(uartDataIn)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] rd;
    logic       chk_rd;
    logic [7:0] lat;
  } exp_t;

  exp_t  sb[$];
  string sb_nm[$];
  int    n_chk = 0, n_fail = 0;
  int    cyc = 0, strobe_cyc = 0, ack_count = 0, req_cycles = 0;
  int    tx_delay = 1, rx_delay = 1, tx_cnt = 0, rx_cnt = 0;
  logic  prev_ack = 1'b0;
  logic [10:0] exp_din = 11'h000, rx_word = 11'h000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // TX/RX FIFO models: ack after the configured number of request cycles.
  always @(posedge clk) begin
    #1;
    if (uartWriteReq) begin
      tx_cnt++;
      uartWriteAck = (tx_cnt == tx_delay);
    end else begin
      tx_cnt = 0;
      uartWriteAck = 1'b0;
    end
    if (uartReadReq) begin
      rx_cnt++;
      uartReadAck = (rx_cnt == rx_delay);
    end else begin
      rx_cnt = 0;
      uartReadAck = 1'b0;
    end
    uartDataOut = rx_word;
  end

  // Monitor: every busAck pops one expectation.
  always @(negedge clk) begin
    if (busAck) begin
      if (prev_ack) chk("ack_width", 32'd2, 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t  e;
        string nm;
        e  = sb.pop_front();
        nm = sb_nm.pop_front();
        if (e.chk_rd) chk({nm, "_rd"}, {24'd0, busRdData}, {24'd0, e.rd});
        chk({nm, "_lat"}, cyc - strobe_cyc, {24'd0, e.lat});
      end
      ack_count++;
    end
    prev_ack = busAck;
    if (uartWriteReq) begin
      req_cycles++;
      chk("tx_data_in", {21'd0, uartDataIn}, {21'd0, exp_din});
    end
  end

  task automatic access(input logic wr, input logic [2:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input int lat, input string nm);
    int start;
    exp_t e;
    @(posedge clk); #1;
    busStrobe = 1'b1; busWrite = wr; busAddr = a; busWrData = d;
    strobe_cyc = cyc;
    e.rd = exp_rd; e.chk_rd = !wr; e.lat = 8'(lat);
    sb.push_back(e);
    sb_nm.push_back(nm);
    start = ack_count;
    @(posedge clk); #1;
    busStrobe = 1'b0;
    for (int i = 0; i < 60 && ack_count == start; i++) @(posedge clk);
    if (ack_count == start) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
      sb.delete();
      sb_nm.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busAck", {31'd0, busAck}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_reqs", {30'd0, uartReadReq, uartWriteReq}, 32'd0);
    chk("rst_data_in", {21'd0, uartDataIn}, 32'd0);
    chk("rst_divisor", {8'd0, clockDivisor}, 32'd104);
    chk("rst_dataBits", {30'd0, dataBits}, 32'd3);
    chk("rst_line_cfg", {28'd0, hasParity, parityMode, extraStopBit}, 32'd0);
    rst = 1'b0;

    access(0, ADDR_CONFIG,  8'h00, 8'h03, 1, "rd_config_rst");
    access(0, ADDR_DIV_LO,  8'h00, 8'h68, 1, "rd_div_lo_rst");
    access(0, ADDR_DIV_MID, 8'h00, 8'h00, 1, "rd_div_mid_rst");
    access(0, ADDR_DIV_HI,  8'h00, 8'h00, 1, "rd_div_hi_rst");
    access(0, 3'd7,         8'h00, 8'h00, 1, "rd_addr7");

    access(1, ADDR_DIV_LO,  8'h12, 8'h00, 1, "wr_div_lo");
    access(1, ADDR_DIV_MID, 8'h34, 8'h00, 1, "wr_div_mid");
    access(1, ADDR_DIV_HI,  8'h56, 8'h00, 1, "wr_div_hi");
    chk("divisor_written", {8'd0, clockDivisor}, 32'h563412);
    access(0, ADDR_DIV_MID, 8'h00, 8'h34, 1, "rd_div_mid");

    // TX push acked on the 4th request cycle
    tx_delay = 4; exp_din = 11'h0A5; req_cycles = 0;
    access(1, ADDR_DATA, 8'hA5, 8'h00, 6, "tx_push");
    chk("tx_req_cycles", req_cycles, 32'd4);
    chk("tx_req_dropped", {31'd0, uartWriteReq}, 32'd0);

    uartFull = 1'b1; req_cycles = 0;
    access(1, ADDR_DATA, 8'h77, 8'h00, 2, "tx_full_reject");
    chk("tx_full_no_req", req_cycles, 32'd0);
    access(0, ADDR_STATUS, 8'h00, 8'h10, 1, "status_full");
    uartFull = 1'b0;
    access(0, ADDR_STATUS, 8'h00, 8'h12, 1, "status_tx_dropped");
    access(1, ADDR_STATUS, 8'h10, 8'h00, 1, "wr_status_clr_txd");
    access(0, ADDR_STATUS, 8'h00, 8'h02, 1, "status_txd_cleared");

    // RX pops: parityError only, then overflow only, then underflow
    uartEmpty = 1'b0; rx_word = 11'h15C; rx_delay = 1;
    access(0, ADDR_DATA, 8'h00, 8'h5C, 3, "rx_pop_parity");
    access(0, ADDR_STATUS, 8'h00, 8'h07, 1, "status_parity");
    rx_word = 11'h2AA; rx_delay = 2;
    access(0, ADDR_DATA, 8'h00, 8'hAA, 4, "rx_pop_overflow");
    access(0, ADDR_STATUS, 8'h00, 8'h0B, 1, "status_overflow");
    uartEmpty = 1'b1;
    access(0, ADDR_DATA, 8'h00, 8'h00, 2, "rx_underflow");
    access(0, ADDR_STATUS, 8'h00, 8'h2A, 1, "status_underflow");

    access(1, ADDR_CONFIG, 8'hFE, 8'h00, 1, "wr_config");
    chk("cfg_ports", {26'd0, dataBits, hasParity, parityMode, extraStopBit}, {26'd0, 2'd2, 1'b1, 2'd3, 1'b1});
    access(0, ADDR_CONFIG, 8'h00, 8'h3E, 1, "rd_config");

    // Strobe during TX_WAIT must be ignored entirely
    tx_delay = 5; exp_din = 11'h03C;
    fork
      access(1, ADDR_DATA, 8'h3C, 8'h00, 7, "tx_busy");
      begin
        repeat (2) @(posedge clk);
        #2; busStrobe = 1'b1; busWrite = 1'b1; busAddr = ADDR_CONFIG; busWrData = 8'h00;
        @(posedge clk);
        #2; busStrobe = 1'b0; busAddr = ADDR_DATA;
      end
    join
    access(0, ADDR_CONFIG, 8'h00, 8'h3E, 1, "config_unchanged");

    // Interrupt sources
    access(1, ADDR_IRQ_EN, 8'h04, 8'h00, 1, "wr_irq_en_sticky");
    @(posedge clk); #1;
    chk("irq_sticky", {31'd0, irq}, 32'd1);
    access(1, ADDR_STATUS, 8'h30, 8'h00, 1, "wr_status_clr_all");
    @(posedge clk); #1;
    chk("irq_sticky_cleared", {31'd0, irq}, 32'd0);
    access(1, ADDR_IRQ_EN, 8'h01, 8'h00, 1, "wr_irq_en_rx");
    access(0, ADDR_IRQ_EN, 8'h00, 8'h01, 1, "rd_irq_en");
    chk("irq_rx_idle", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    uartEmpty = 1'b0;
    @(negedge clk);
    chk("irq_not_yet", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_rx_rise", {31'd0, irq}, 32'd1);

    // Reset during RX_WAIT
    rx_delay = 30;
    @(posedge clk); #1;
    busStrobe = 1'b1; busWrite = 1'b0; busAddr = ADDR_DATA;
    @(posedge clk); #1;
    busStrobe = 1'b0;
    @(posedge clk); #2;
    chk("rx_wait_req", {31'd0, uartReadReq}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_req", {31'd0, uartReadReq}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_divisor", {8'd0, clockDivisor}, 32'd104);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_ack", {31'd0, busAck}, 32'd0);
    rx_delay = 1; rx_word = 11'h033;
    access(0, ADDR_DATA, 8'h00, 8'h33, 3, "rx_after_reset");
    access(0, ADDR_CONFIG, 8'h00, 8'h03, 1, "config_after_reset");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
